// File: rtl/mem_stage_ooo_resp.sv
// mem_stage_ooo_resp
// MEM pipeline stage between EX and WB. Load data comes back on a
// request/response bus with arbitrary latency (data_ok, in order). A response
// that arrives while WB stalls is held in a buffer. Responses that belong to
// flushed loads are discarded by a small counter. Returned data is aligned and
// sign/zero-extended. A forwarding bundle, with a "not yet available" flag,
// goes to the ID hazard unit.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   in_valid / mem_allowin            EX -> MEM handshake
//   in_pc, in_rf_we, in_rf_waddr      instruction fields from EX
//   in_alu_result                     load address or final result
//   in_ld_op                          0 none,1 b,2 bu,3 h,4 hu,5 w,6 wu,7 d
//   in_req_sent                       EX issued the bus read for this load
//   data_ok, data_rdata               read response
//   flush                             cancel the instruction held in MEM
//   wb_allowin / out_valid            MEM -> WB handshake
//   out_pc, out_rf_we, out_rf_waddr, out_rf_wdata   fields to WB
//   fwd_we, fwd_waddr, fwd_wdata, fwd_pending        forwarding bundle
module mem_stage_ooo_resp #(
    parameter int DW     = 32,
    parameter int DISC_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              mem_allowin,
    input  logic [31:0]       in_pc,
    input  logic              in_rf_we,
    input  logic [4:0]        in_rf_waddr,
    input  logic [DW-1:0]     in_alu_result,
    input  logic [2:0]        in_ld_op,
    input  logic              in_req_sent,
    input  logic              data_ok,
    input  logic [DW-1:0]     data_rdata,
    input  logic              flush,
    input  logic              wb_allowin,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic              out_rf_we,
    output logic [4:0]        out_rf_waddr,
    output logic [DW-1:0]     out_rf_wdata,
    output logic              fwd_we,
    output logic [4:0]        fwd_waddr,
    output logic [DW-1:0]     fwd_wdata,
    output logic              fwd_pending
);

    localparam int OFF = $clog2(DW / 8);

    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;

    state_t             state_reg;
    logic [DISC_W-1:0]  disc_cnt_reg;
    logic [DW-1:0]      buf_reg;
    logic               buf_used_reg;   // READY state holds captured load data
    logic [31:0]        pc_reg;
    logic               rf_we_reg;
    logic [4:0]         rf_waddr_reg;
    logic [DW-1:0]      alu_reg;
    logic [2:0]         ld_op_reg;

    logic               valid;
    logic               disc_zero;
    logic               resp_here;      // response belongs to the load in MEM
    logic               ready_go;
    logic               capture;
    logic               handoff;
    logic [OFF+2:0]     sh;
    logic [DW-1:0]      shifted;
    logic [DW-1:0]      ext_data;

    assign valid       = (state_reg != S_EMPTY);
    assign disc_zero   = (disc_cnt_reg == '0);
    assign resp_here   = (state_reg == S_WAIT) & data_ok & disc_zero;
    assign ready_go    = (state_reg == S_READY) | resp_here;
    assign out_valid   = valid & ready_go & ~flush;
    assign mem_allowin = ~flush & (~valid | (ready_go & wb_allowin));
    assign capture     = in_valid & mem_allowin;
    assign handoff     = out_valid & wb_allowin;

    // Alignment uses the address captured with the load, not the one EX is
    // presenting now.
    assign sh      = {alu_reg[OFF-1:0], 3'b000};
    assign shifted = data_rdata >> sh;

    // For DW=32 the word cases are full width, so wu and d fall out as w.
    always_comb begin
        ext_data = shifted;
        case (ld_op_reg)
            3'd1:    ext_data = DW'($signed(shifted[7:0]));
            3'd2:    ext_data = DW'(shifted[7:0]);
            3'd3:    ext_data = DW'($signed(shifted[15:0]));
            3'd4:    ext_data = DW'(shifted[15:0]);
            3'd5:    ext_data = DW'($signed(shifted[31:0]));
            3'd6:    ext_data = DW'(shifted[31:0]);
            default: ext_data = shifted;
        endcase
    end

    always_comb begin
        out_rf_wdata = alu_reg;
        if (state_reg == S_READY && buf_used_reg) begin
            out_rf_wdata = buf_reg;
        end else if (state_reg == S_WAIT) begin
            out_rf_wdata = ext_data;
        end
    end

    assign out_pc       = pc_reg;
    assign out_rf_we    = rf_we_reg;
    assign out_rf_waddr = rf_waddr_reg;
    assign fwd_we       = valid & rf_we_reg;
    assign fwd_waddr    = rf_waddr_reg;
    assign fwd_wdata    = out_rf_wdata;
    assign fwd_pending  = (state_reg == S_WAIT) & ~(data_ok & disc_zero);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_EMPTY;
            disc_cnt_reg <= '0;
            buf_reg      <= '0;
            buf_used_reg <= 1'b0;
            pc_reg       <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            alu_reg      <= '0;
            ld_op_reg    <= '0;
        end else begin
            // A flushed load that still awaits its response leaves one orphan
            // response on the bus. If a stale response also arrives this
            // cycle, the +1 and -1 cancel out.
            if (flush && state_reg == S_WAIT && !(data_ok && disc_zero)) begin
                if (!data_ok && disc_cnt_reg != '1) begin
                    disc_cnt_reg <= disc_cnt_reg + 1'b1;
                end
            end else if (data_ok && !disc_zero) begin
                disc_cnt_reg <= disc_cnt_reg - 1'b1;
            end

            if (flush) begin
                state_reg <= S_EMPTY;
            end else if (capture) begin
                pc_reg       <= in_pc;
                rf_waddr_reg <= in_rf_waddr;
                alu_reg      <= in_alu_result;
                ld_op_reg    <= in_ld_op;
                buf_used_reg <= 1'b0;
                // A load that never reached the bus must not write the RF.
                rf_we_reg    <= in_rf_we & ~((in_ld_op != 3'd0) & ~in_req_sent);
                state_reg    <= ((in_ld_op != 3'd0) && in_req_sent) ? S_WAIT : S_READY;
            end else if (resp_here && !wb_allowin) begin
                buf_reg      <= ext_data;
                buf_used_reg <= 1'b1;
                state_reg    <= S_READY;
            end else if (handoff) begin
                state_reg    <= S_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ooo_resp.sv
module tb_mem_stage_ooo_resp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid32, in_valid64;
    logic [31:0] in_pc;
    logic        in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic [31:0] alu32;
    logic [63:0] alu64;
    logic [2:0]  in_ld_op;
    logic        in_req_sent;
    logic        data_ok;
    logic [31:0] rdata32;
    logic [63:0] rdata64;
    logic        flush;
    logic        wb_allowin;

    logic        allow32, ov32, we32, fwe32, fp32;
    logic [31:0] pc32, wd32, fwd32;
    logic [4:0]  wa32, fwa32;
    logic        allow64, ov64, we64, fwe64, fp64;
    logic [31:0] pc64;
    logic [63:0] wd64, fwd64;
    logic [4:0]  wa64, fwa64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ooo_resp #(.DW(32), .DISC_W(2)) dut32 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid32), .mem_allowin(allow32),
        .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_alu_result(alu32), .in_ld_op(in_ld_op), .in_req_sent(in_req_sent),
        .data_ok(data_ok), .data_rdata(rdata32), .flush(flush), .wb_allowin(wb_allowin),
        .out_valid(ov32), .out_pc(pc32), .out_rf_we(we32), .out_rf_waddr(wa32),
        .out_rf_wdata(wd32), .fwd_we(fwe32), .fwd_waddr(fwa32), .fwd_wdata(fwd32),
        .fwd_pending(fp32)
    );

    mem_stage_ooo_resp #(.DW(64), .DISC_W(2)) dut64 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid64), .mem_allowin(allow64),
        .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_alu_result(alu64), .in_ld_op(in_ld_op), .in_req_sent(in_req_sent),
        .data_ok(data_ok), .data_rdata(rdata64), .flush(flush), .wb_allowin(wb_allowin),
        .out_valid(ov64), .out_pc(pc64), .out_rf_we(we64), .out_rf_waddr(wa64),
        .out_rf_wdata(wd64), .fwd_we(fwe64), .fwd_waddr(fwa64), .fwd_wdata(fwd64),
        .fwd_pending(fp64)
    );

    // Flushing a waiting load while the discard counter is already full is a
    // protocol error; the counter would silently saturate.
    always @(posedge clk) begin
        if (resetn) begin
            assert (!(flush && fp32 && !data_ok && (&dut32.disc_cnt_reg)))
                else $error("discard counter overflow on flush");
        end
    end

    typedef struct {
        logic        dw64;
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_valid32  = 1'b0;
        in_valid64  = 1'b0;
        data_ok     = 1'b0;
        flush       = 1'b0;
        wb_allowin  = 1'b1;
        in_req_sent = 1'b0;
        in_ld_op    = 3'd0;
        rdata32     = 32'h0;
        rdata64     = 64'h0;
    endtask

    // One load (or non-load) through the stage with WB always ready.
    task automatic run_vec(input int i);
        vec_t v;
        logic ov, fp, fwe, allow;
        logic [63:0] wd;
        v = vecs[i];
        @(negedge clk);
        idle();
        in_pc       = 32'h100 + 32'(i * 4);
        in_rf_we    = 1'b1;
        in_rf_waddr = 5'(i + 1);
        in_ld_op    = v.op;
        in_req_sent = (v.op != 3'd0);
        if (v.dw64) begin
            in_valid64 = 1'b1;
            alu64      = v.addr;
        end else begin
            in_valid32 = 1'b1;
            alu32      = v.addr[31:0];
        end
        #1;
        allow = v.dw64 ? allow64 : allow32;
        chk($sformatf("v%0d allowin", i), 64'(allow), 64'd1);

        @(negedge clk);
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        #1;
        if (v.op != 3'd0) begin
            ov  = v.dw64 ? ov64  : ov32;
            fp  = v.dw64 ? fp64  : fp32;
            fwe = v.dw64 ? fwe64 : fwe32;
            chk($sformatf("v%0d wait pending", i), 64'(fp), 64'd1);
            chk($sformatf("v%0d wait out_valid", i), 64'(ov), 64'd0);
            chk($sformatf("v%0d wait fwd_we", i), 64'(fwe), 64'd1);
            data_ok = 1'b1;
            rdata64 = v.rdata;
            rdata32 = v.rdata[31:0];
            #1;
        end
        ov = v.dw64 ? ov64 : ov32;
        fp = v.dw64 ? fp64 : fp32;
        wd = v.dw64 ? wd64 : 64'(wd32);
        chk($sformatf("v%0d out_valid", i), 64'(ov), 64'd1);
        chk($sformatf("v%0d wdata", i), wd, v.exp);
        chk($sformatf("v%0d pending clear", i), 64'(fp), 64'd0);
        chk($sformatf("v%0d out_pc", i), 64'(v.dw64 ? pc64 : pc32), 64'(32'h100 + 32'(i * 4)));

        @(negedge clk);
        idle();
        #1;
        ov = v.dw64 ? ov64 : ov32;
        chk($sformatf("v%0d out_valid drop", i), 64'(ov), 64'd0);
        $display("vec %0d dw64=%0d op=%0d addr=0x%0h rdata=0x%0h exp=0x%0h", i, v.dw64, v.op, v.addr, v.rdata, v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        vecs[0]  = '{1'b0, 3'd1, 64'h1003, 64'h80FF1234, 64'hFFFFFF80};
        vecs[1]  = '{1'b0, 3'd2, 64'h1003, 64'h80FF1234, 64'h00000080};
        vecs[2]  = '{1'b0, 3'd3, 64'h2002, 64'h9ABC0000, 64'hFFFF9ABC};
        vecs[3]  = '{1'b0, 3'd4, 64'h2002, 64'h9ABC0000, 64'h00009ABC};
        vecs[4]  = '{1'b0, 3'd5, 64'h3000, 64'h12345678, 64'h12345678};
        vecs[5]  = '{1'b0, 3'd0, 64'h1234, 64'h0,        64'h1234};
        vecs[6]  = '{1'b0, 3'd1, 64'h1001, 64'h80FF1234, 64'h00000012};
        vecs[7]  = '{1'b1, 3'd6, 64'h4004, 64'h8000000100000000, 64'h0000000080000001};
        vecs[8]  = '{1'b1, 3'd5, 64'h4004, 64'h8000000100000000, 64'hFFFFFFFF80000001};
        vecs[9]  = '{1'b1, 3'd7, 64'h4000, 64'h8000000100000000, 64'h8000000100000000};
        vecs[10] = '{1'b1, 3'd3, 64'h4006, 64'h8000000100000000, 64'hFFFFFFFFFFFF8000};

        resetn      = 1'b0;
        in_pc       = 32'h0;
        in_rf_we    = 1'b0;
        in_rf_waddr = 5'd0;
        alu32       = 32'h0;
        alu64       = 64'h0;
        idle();
        #3;
        chk("reset out_valid32", 64'(ov32), 64'd0);
        chk("reset out_pc32", 64'(pc32), 64'd0);
        chk("reset wdata32", 64'(wd32), 64'd0);
        chk("reset fwd_we32", 64'(fwe32), 64'd0);
        chk("reset pending32", 64'(fp32), 64'd0);
        chk("reset out_valid64", 64'(ov64), 64'd0);
        chk("reset wdata64", wd64, 64'd0);
        $display("reset state checked");
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(i);
        end

        // Load whose request never went out: READY with write enable dropped.
        @(negedge clk);
        idle();
        in_valid32 = 1'b1; in_ld_op = 3'd5; in_req_sent = 1'b0;
        in_rf_we = 1'b1; in_rf_waddr = 5'd7; alu32 = 32'h40; in_pc = 32'h300;
        @(negedge clk);
        idle();
        #1;
        chk("noreq out_valid", 64'(ov32), 64'd1);
        chk("noreq rf_we", 64'(we32), 64'd0);
        chk("noreq fwd_we", 64'(fwe32), 64'd0);
        chk("noreq wdata", 64'(wd32), 64'h40);
        $display("load without request checked");

        // Back-to-back: hand-off of A and capture of B in one cycle.
        @(negedge clk);
        idle();
        in_valid32 = 1'b1; in_rf_we = 1'b1; alu32 = 32'hAAAA; in_pc = 32'h200;
        @(negedge clk);
        alu32 = 32'hBBBB; in_pc = 32'h204;
        #1;
        chk("b2b A out_valid", 64'(ov32), 64'd1);
        chk("b2b A pc", 64'(pc32), 64'h200);
        chk("b2b A wdata", 64'(wd32), 64'hAAAA);
        chk("b2b allowin", 64'(allow32), 64'd1);
        @(negedge clk);
        idle();
        #1;
        chk("b2b B out_valid", 64'(ov32), 64'd1);
        chk("b2b B pc", 64'(pc32), 64'h204);
        chk("b2b B wdata", 64'(wd32), 64'hBBBB);
        @(negedge clk);
        #1;
        chk("b2b drain", 64'(ov32), 64'd0);
        $display("back-to-back sequence checked");

        // Response arrives while WB stalls for 3 cycles: buffered, one pulse.
        @(negedge clk);
        idle();
        in_valid32 = 1'b1; in_ld_op = 3'd5; in_req_sent = 1'b1; alu32 = 32'h0;
        @(negedge clk);
        idle();
        wb_allowin = 1'b0; data_ok = 1'b1; rdata32 = 32'hCAFEF00D;
        #1;
        chk("stall c1 out_valid", 64'(ov32), 64'd1);
        chk("stall c1 wdata", 64'(wd32), 64'hCAFEF00D);
        chk("stall c1 allowin", 64'(allow32), 64'd0);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            data_ok = 1'b0; rdata32 = 32'h11111111;
            #1;
            chk($sformatf("stall c%0d out_valid", c), 64'(ov32), 64'd1);
            chk($sformatf("stall c%0d wdata", c), 64'(wd32), 64'hCAFEF00D);
            chk($sformatf("stall c%0d allowin", c), 64'(allow32), 64'd0);
            chk($sformatf("stall c%0d pending", c), 64'(fp32), 64'd0);
        end
        pulses = 0;
        @(negedge clk);
        wb_allowin = 1'b1;
        #1;
        chk("stall release wdata", 64'(wd32), 64'hCAFEF00D);
        chk("stall release allowin", 64'(allow32), 64'd1);
        if (ov32) pulses++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            if (ov32) pulses++;
        end
        chk("stall pulse count", 64'(pulses), 64'd1);
        $display("stall buffering checked, pulses=%0d", pulses);

        // Flush in WAIT, new load, then orphan 0xDEAD and real 0xBEEF.
        @(negedge clk);
        idle();
        in_valid32 = 1'b1; in_ld_op = 3'd5; in_req_sent = 1'b1; alu32 = 32'h0;
        in_rf_we = 1'b1; in_pc = 32'h400;
        @(negedge clk);
        idle();
        flush = 1'b1;
        #1;
        chk("flush out_valid", 64'(ov32), 64'd0);
        chk("flush allowin", 64'(allow32), 64'd0);
        @(negedge clk);
        idle();
        in_valid32 = 1'b1; in_ld_op = 3'd5; in_req_sent = 1'b1; alu32 = 32'h0; in_pc = 32'h404;
        #1;
        chk("flush disc=1", 64'(dut32.disc_cnt_reg), 64'd1);
        chk("flush then allowin", 64'(allow32), 64'd1);
        @(negedge clk);
        idle();
        data_ok = 1'b1; rdata32 = 32'hDEAD;
        #1;
        chk("orphan pending", 64'(fp32), 64'd1);
        chk("orphan out_valid", 64'(ov32), 64'd0);
        @(negedge clk);
        rdata32 = 32'hBEEF;
        #1;
        chk("orphan disc=0", 64'(dut32.disc_cnt_reg), 64'd0);
        chk("real out_valid", 64'(ov32), 64'd1);
        chk("real wdata", 64'(wd32), 64'hBEEF);
        chk("real pc", 64'(pc32), 64'h404);
        @(negedge clk);
        idle();
        #1;
        chk("real drain", 64'(ov32), 64'd0);
        $display("flush with orphan response checked");

        // Flush and data_ok in the same WAIT cycle: no orphan recorded.
        @(negedge clk);
        idle();
        in_valid32 = 1'b1; in_ld_op = 3'd5; in_req_sent = 1'b1;
        @(negedge clk);
        idle();
        flush = 1'b1; data_ok = 1'b1; rdata32 = 32'h5555;
        #1;
        chk("flush+ok out_valid", 64'(ov32), 64'd0);
        @(negedge clk);
        idle();
        #1;
        chk("flush+ok disc", 64'(dut32.disc_cnt_reg), 64'd0);
        chk("flush+ok empty", 64'(fwe32), 64'd0);
        $display("flush with same-cycle response checked");

        // Asynchronous reset while a load waits.
        @(negedge clk);
        idle();
        in_valid32 = 1'b1; in_ld_op = 3'd5; in_req_sent = 1'b1;
        in_rf_we = 1'b1; in_rf_waddr = 5'd9; alu32 = 32'h80; in_pc = 32'h500;
        @(negedge clk);
        idle();
        #1;
        chk("pre-reset pending", 64'(fp32), 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("async reset pending", 64'(fp32), 64'd0);
        chk("async reset out_valid", 64'(ov32), 64'd0);
        chk("async reset pc", 64'(pc32), 64'd0);
        chk("async reset fwd_we", 64'(fwe32), 64'd0);
        chk("async reset waddr", 64'(fwa32), 64'd0);
        chk("async reset wdata", 64'(fwd32), 64'd0);
        chk("async reset rf_we", 64'(we32), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post reset out_valid", 64'(ov32), 64'd0);
        $display("asynchronous reset checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
